button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 158 +++++++++++++++
 tb/tb_button_conditioner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Front-panel conditioner: synchronizes and debounces Run/Continue keys into one-cycle pulses, syncs S.
// Define CONTINUE_AUTO_REPEAT_EN to make a held Continue key auto-repeat every REPEAT_CYCLES clocks.

module button_conditioner_key #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 12500000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n_i,
  output logic       pulse_o,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] RP_LAST = 24'(REPEAT_CYCLES - 1);

  state_t      state_q;
  logic [19:0] cnt_q;
  logic        pulse_q;
  logic        rep_fire;

  generate
    if (REPEAT_EN) begin : g_repeat
      logic [23:0] rep_q;
      assign rep_fire = (state_q == HELD) && (rep_q == RP_LAST);
      // Runs only while HELD; any excursion out of HELD restarts the period.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rep_q <= '0;
        end else if (state_q != HELD || rep_fire) begin
          rep_q <= '0;
        end else begin
          rep_q <= rep_q + 24'd1;
        end
      end
    end else begin : g_no_repeat
      assign rep_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= rep_fire;
      case (state_q)
        IDLE: begin
          if (!key_n_i) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (key_n_i) begin
            state_q <= IDLE;
          end else if (cnt_q == DB_LAST) begin
            state_q <= HELD;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        HELD: begin
          if (key_n_i) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_n_i) begin
            state_q <= HELD;
          end else if (cnt_q == DB_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pulse_o = pulse_q;
  assign state_o = state_q;
endmodule

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run_raw,
  input  logic        Continue_raw,
  input  logic [15:0] S_raw,
  output logic        Run,
  output logic        Continue,
  output logic [15:0] S,
  output logic [1:0]  run_state_o,
  output logic [1:0]  cont_state_o
);
`ifdef CONTINUE_AUTO_REPEAT_EN
  localparam bit CONT_REPEAT = 1'b1;
`else
  localparam bit CONT_REPEAT = 1'b0;
`endif

  logic [1:0]  run_sync_q;
  logic [1:0]  cont_sync_q;
  logic [15:0] s_meta_q;
  logic [15:0] s_sync_q;

  // Key synchronizers reset to the released (high) level so reset never looks like a press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_sync_q  <= 2'b11;
      cont_sync_q <= 2'b11;
      s_meta_q    <= '0;
      s_sync_q    <= '0;
    end else begin
      run_sync_q  <= {run_sync_q[0], Run_raw};
      cont_sync_q <= {cont_sync_q[0], Continue_raw};
      s_meta_q    <= S_raw;
      s_sync_q    <= s_meta_q;
    end
  end

  assign S = s_sync_q;

  button_conditioner_key #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b0)
  ) u_run (
    .clk    (Clk),
    .rst    (Reset),
    .key_n_i(run_sync_q[1]),
    .pulse_o(Run),
    .state_o(run_state_o)
  );

  button_conditioner_key #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (CONT_REPEAT)
  ) u_cont (
    .clk    (Clk),
    .rst    (Reset),
    .key_n_i(cont_sync_q[1]),
    .pulse_o(Continue),
    .state_o(cont_state_o)
  );
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_button_conditioner;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PW   = 2'd1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Run_raw = 1'b1;
  logic        Continue_raw = 1'b1;
  logic [15:0] S_raw = 16'h0000;
  logic        Run;
  logic        Continue;
  logic [15:0] S;
  logic [1:0]  run_state_o;
  logic [1:0]  cont_state_o;

  int n_vec = 0;
  int n_fail = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Run_raw     (Run_raw),
    .Continue_raw(Continue_raw),
    .S_raw       (S_raw),
    .Run         (Run),
    .Continue    (Continue),
    .S           (S),
    .run_state_o (run_state_o),
    .cont_state_o(cont_state_o)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cont_expected(input int k);
`ifdef CONTINUE_AUTO_REPEAT_EN
    return (k == 7) || (k == 15) || (k == 23) || (k == 31) || (k == 39);
`else
    return (k == 7);
`endif
  endfunction

  initial begin
    int pulses;
    // Reset state
    #12;
    check("reset_run", {15'd0, Run}, 16'd0);
    check("reset_cont", {15'd0, Continue}, 16'd0);
    check("reset_s", S, 16'h0000);
    check("reset_run_state", {14'd0, run_state_o}, {14'd0, ST_IDLE});
    @(negedge Clk);
    Reset = 1'b0;
    tick();

    // Held press: single pulse after edge 7
    Run_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("hold_run_e%0d", k), {15'd0, Run}, {15'd0, (k == 7)});
    end
    Run_raw = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("release_idle", {14'd0, run_state_o}, {14'd0, ST_IDLE});

    // Short bounce rejected
    Run_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) Run_raw = 1'b1;
      tick();
      check($sformatf("bounce_run_e%0d", k), {15'd0, Run}, 16'd0);
      if (k == 4) check("bounce_pw", {14'd0, run_state_o}, {14'd0, ST_PW});
    end
    check("bounce_idle", {14'd0, run_state_o}, {14'd0, ST_IDLE});

    // Press, short release, press again: one pulse total
    pulses = 0;
    Run_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); pulses += int'(Run); end
    Run_raw = 1'b1;
    for (int k = 0; k < 2; k++) begin tick(); pulses += int'(Run); end
    Run_raw = 1'b0;
    for (int k = 0; k < 15; k++) begin tick(); pulses += int'(Run); end
    check("reglitch_pulses", 16'(pulses), 16'd1);
    Run_raw = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    // Simultaneous press, held 40 cycles
    Run_raw = 1'b0;
    Continue_raw = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("both_run_e%0d", k), {15'd0, Run}, {15'd0, (k == 7)});
      check($sformatf("both_cont_e%0d", k), {15'd0, Continue}, {15'd0, cont_expected(k)});
    end
    Run_raw = 1'b1;
    Continue_raw = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check("both_cont_idle", {14'd0, cont_state_o}, {14'd0, ST_IDLE});

    // Switch synchronizer: exactly two edges of delay
    S_raw = 16'hA5C3;
    tick();
    check("s_e1", S, 16'h0000);
    tick();
    check("s_e2", S, 16'hA5C3);
    S_raw = 16'h5A3C;
    tick();
    check("s2_e1", S, 16'hA5C3);
    tick();
    check("s2_e2", S, 16'h5A3C);

    // Reset mid-debounce, then key held through reset release
    Run_raw = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #2;
    Reset = 1'b1;
    #1;
    check("rst_mid_s", S, 16'h0000);
    check("rst_mid_run", {15'd0, Run}, 16'd0);
    check("rst_mid_state", {14'd0, run_state_o}, {14'd0, ST_IDLE});
    tick();
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("post_rst_run_e%0d", k), {15'd0, Run}, {15'd0, (k == 7)});
    end
    Run_raw = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    // Reset during the pulse cycle clears it at once
    Run_raw = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("pre_rst_pulse", {15'd0, Run}, 16'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_pulse_run", {15'd0, Run}, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    Run_raw = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
